// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: RV32M multiply/divide unit for the EX stage.
// Multiply uses iterative radix-2 shift-add on 32-bit magnitudes. Divide uses
// restoring shift-subtract on 32-bit magnitudes. Signs are fixed up when the
// result is captured.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid, op         RV32M instruction present in EX, funct3 selector
//   rs1_dat, rs2_dat      forwarded operands
//   flush                 kill the instruction currently in EX
//   stall_ext             downstream freeze; holds the result window open
//   stall_req             holds IF/ID/EX while an operation is in flight
//   result_valid, result  RV32M result for the EX/MEM capture
//
// Optional feature: define MULDIV_FAST_MUL_EN to replace the iterative
// multiply with a single-cycle combinational multiplier. That mode finishes
// ops 0-3 one cycle after acceptance.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs1_dat,
    input  logic [31:0] rs2_dat,
    input  logic        flush,
    input  logic        stall_ext,
    output logic        stall_req,
    output logic        result_valid,
    output logic [31:0] result
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_s1;
    logic              r_s2;
    logic [XLEN:0]     r_hi;      // mul: running upper product; div: partial remainder
    logic [XLEN-1:0]   r_lo;      // mul: multiplier/low product; div: dividend/quotient
    logic [XLEN-1:0]   r_b;       // mul: multiplicand; div: divisor
    logic [XLEN-1:0]   r_result;

    // Operand decode at acceptance
    logic            w_sgn1_op;
    logic            w_sgn2_op;
    logic            w_s1;
    logic            w_s2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_special;

    assign w_sgn1_op = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign w_sgn2_op = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign w_s1      = rs1_dat[XLEN-1] & w_sgn1_op;
    assign w_s2      = rs2_dat[XLEN-1] & w_sgn2_op;
    assign w_mag1    = w_s1 ? (XLEN'(0) - rs1_dat) : rs1_dat;
    assign w_mag2    = w_s2 ? (XLEN'(0) - rs2_dat) : rs2_dat;
    assign w_div0    = op[2] && (rs2_dat == '0);
    // Signed overflow applies only to DIV (4) and REM (6)
    assign w_ovf     = op[2] && !op[0] && (rs1_dat == 32'h8000_0000) && (rs2_dat == 32'hFFFF_FFFF);
    // Short-circuit results; op[1] separates REM* from DIV*
    assign w_special = w_div0 ? (op[1] ? rs1_dat : 32'hFFFF_FFFF)
                              : (op[1] ? 32'h0000_0000 : 32'h8000_0000);

`ifdef MULDIV_FAST_MUL_EN
    // 33x33 signed product; 64-bit truncating multiply of sign-extended operands
    logic [2*XLEN-1:0] w_m1;
    logic [2*XLEN-1:0] w_m2;
    logic [2*XLEN-1:0] w_fast;
    assign w_m1   = {{XLEN{w_s1}}, rs1_dat};
    assign w_m2   = {{XLEN{w_s2}}, rs2_dat};
    assign w_fast = w_m1 * w_m2;
`endif

    // One radix-2 step
    logic [XLEN:0]   w_add;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic [XLEN:0]   w_hi_nx;
    logic [XLEN-1:0] w_lo_nx;

    assign w_add   = r_hi + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_shift = {r_hi[XLEN-1:0], r_lo[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_b};

    always_comb begin
        w_hi_nx = r_hi;
        w_lo_nx = r_lo;
        if (r_op[2]) begin
            if (!w_trial[XLEN]) begin
                w_hi_nx = w_trial;
                w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_nx = w_shift;
                w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            w_hi_nx = {1'b0, w_add[XLEN:1]};
            w_lo_nx = {w_add[0], r_lo[XLEN-1:1]};
        end
    end

    // Sign fix and result select for the final step
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_final;

    assign w_prod     = {w_hi_nx[XLEN-1:0], w_lo_nx};
    assign w_prod_fix = (r_s1 ^ r_s2) ? ((2*XLEN)'(0) - w_prod) : w_prod;
    assign w_quo_fix  = (r_s1 ^ r_s2) ? (XLEN'(0) - w_lo_nx) : w_lo_nx;
    assign w_rem_fix  = r_s1 ? (XLEN'(0) - w_hi_nx[XLEN-1:0]) : w_hi_nx[XLEN-1:0];

    always_comb begin
        w_final = w_rem_fix;
        case (r_op)
            3'd0:                  w_final = w_prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:      w_final = w_prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:            w_final = w_quo_fix;
            default:               w_final = w_rem_fix;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        r_op  <= op;
                        r_s1  <= w_s1;
                        r_s2  <= w_s2;
                        r_cnt <= CNT_W'(XLEN);
                        r_hi  <= '0;
                        r_lo  <= op[2] ? w_mag1 : w_mag2;
                        r_b   <= op[2] ? w_mag2 : w_mag1;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special;
                            r_state  <= S_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!op[2]) begin
                            r_result <= (op == 3'd0) ? w_fast[XLEN-1:0] : w_fast[2*XLEN-1:XLEN];
                            r_state  <= S_DONE;
                        end
`endif
                        else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hi  <= w_hi_nx;
                        r_lo  <= w_lo_nx;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_result <= w_final;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (flush || !stall_ext) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A flush drops the stall and the result window in the same cycle
    assign stall_req    = rst_n && !flush &&
                          (((r_state == S_IDLE) && req_valid) || (r_state == S_BUSY));
    assign result_valid = (r_state == S_DONE) && !flush;
    assign result       = r_result;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed testbench for muldiv_ctrl.
module tb_muldiv_ctrl;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  op;
    logic [31:0] rs1_dat;
    logic [31:0] rs2_dat;
    logic        flush;
    logic        stall_ext;
    logic        stall_req;
    logic        result_valid;
    logic [31:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .op           (op),
        .rs1_dat      (rs1_dat),
        .rs2_dat      (rs2_dat),
        .flush        (flush),
        .stall_ext    (stall_ext),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .result       (result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Accept one instruction now, wait for its result window, check it, return to IDLE
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int bad;
        req_valid = 1'b1;
        op        = f3;
        rs1_dat   = a;
        rs2_dat   = b;
        #1;
        chk({tag, " stall_T"}, 32'(stall_req), 32'd1);
        lat = 0;
        bad = 0;
        do begin
            tick();
            req_valid = 1'b0;
            #1;
            lat++;
            if (!result_valid && stall_req !== 1'b1) bad++;
        end while (!result_valid && lat < 40);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy_stall_gaps"}, 32'(bad), 32'd0);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " done_stall"}, 32'(stall_req), 32'd0);
        tick();
        #1;
        chk({tag, " idle_valid"}, 32'(result_valid), 32'd0);
        chk({tag, " held"}, result, exp_res);
    endtask

    initial begin
        int lat;
        int pulses;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        op        = 3'd0;
        rs1_dat   = 32'd0;
        rs2_dat   = 32'd0;
        flush     = 1'b0;
        stall_ext = 1'b0;
        tick();
        tick();
        #1;
        chk("rst stall_req", 32'(stall_req), 32'd0);
        chk("rst result_valid", 32'(result_valid), 32'd0);
        chk("rst result", result, 32'd0);
        rst_n = 1'b1;

        // Multiply
        run_op("mul_7x-3",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu_max",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhsu_2xu", 3'd2, 32'd2,          32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT);
        run_op("mulh_-1x2",  3'd1, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT);

        // Divide / remainder
        run_op("div_-7/2",   3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem_-7%2",   3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("div_7/-2",   3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7%-2",   3'd6, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 33);
        run_op("divu_100/7", 3'd5, 32'd100,        32'd7,         32'd14,        33);
        run_op("remu_100%7", 3'd7, 32'd100,        32'd7,         32'd2,         33);

        // Short-circuit cases
        run_op("divu_5/0",   3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu_5/0",   3'd7, 32'd5,          32'd0,         32'd5,         1);
        run_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Flush mid-BUSY at T+10
        req_valid = 1'b1; op = 3'd5; rs1_dat = 32'd1000; rs2_dat = 32'd3;
        #1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        #1;
        chk("flush_busy stall_T10", 32'(stall_req), 32'd0);
        chk("flush_busy valid_T10", 32'(result_valid), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_busy stall_T11", 32'(stall_req), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid) pulses++;
            tick();
        end
        chk("flush_busy pulses", 32'(pulses), 32'd0);
        chk("flush_busy result_held", result, 32'd0);

        // Flush in the acceptance cycle
        req_valid = 1'b1; op = 3'd5; rs1_dat = 32'd8; rs2_dat = 32'd0; flush = 1'b1;
        #1;
        chk("flush_acc stall", 32'(stall_req), 32'd0);
        tick();
        req_valid = 1'b0; flush = 1'b0;
        #1;
        chk("flush_acc valid", 32'(result_valid), 32'd0);
        chk("flush_acc stall_next", 32'(stall_req), 32'd0);

        // Flush in DONE
        req_valid = 1'b1; op = 3'd5; rs1_dat = 32'd8; rs2_dat = 32'd0;
        #1;
        tick();
        req_valid = 1'b0;
        #1;
        chk("flush_done valid_pre", 32'(result_valid), 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_done valid", 32'(result_valid), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_done idle_valid", 32'(result_valid), 32'd0);
        chk("flush_done result", result, 32'hFFFF_FFFF);

        // stall_ext held from BUSY through 3 DONE cycles
        req_valid = 1'b1; op = 3'd0; rs1_dat = 32'd6; rs2_dat = 32'd7;
        #1;
        tick();
        req_valid = 1'b0; stall_ext = 1'b1;
        #1;
        lat = 1;
        while (!result_valid && lat < 40) begin
            tick();
            #1;
            lat++;
        end
        chk("stall_ext latency", 32'(lat), 32'(MUL_LAT));
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            if (i == 3) stall_ext = 1'b0;
            #1;
            chk("stall_ext valid", 32'(result_valid), 32'd1);
            chk("stall_ext result", result, 32'd42);
        end
        tick();
        req_valid = 1'b1; op = 3'd5; rs1_dat = 32'd9; rs2_dat = 32'd0;
        #1;
        chk("stall_ext idle_valid", 32'(result_valid), 32'd0);
        chk("stall_ext next_accept", 32'(stall_req), 32'd1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("stall_ext next_valid", 32'(result_valid), 32'd1);
        chk("stall_ext next_result", result, 32'hFFFF_FFFF);
        tick();

        // Reset at T+20 of a DIV
        req_valid = 1'b1; op = 3'd4; rs1_dat = 32'hFFFF_FFF9; rs2_dat = 32'd2;
        #1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_busy stall_req", 32'(stall_req), 32'd0);
        chk("rst_busy valid", 32'(result_valid), 32'd0);
        chk("rst_busy result", result, 32'd0);
        run_op("mul_after_rst", 3'd0, 32'd3, 32'd5, 32'd15, MUL_LAT);

        // Reset while held in DONE
        req_valid = 1'b1; op = 3'd7; rs1_dat = 32'd77; rs2_dat = 32'd0;
        #1;
        tick();
        req_valid = 1'b0; stall_ext = 1'b1;
        #1;
        chk("rst_done pre_valid", 32'(result_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; stall_ext = 1'b0;
        #1;
        chk("rst_done valid", 32'(result_valid), 32'd0);
        chk("rst_done result", result, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
